// File: rtl/seq_mult.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult
// Purpose  : Parametrised sequential shift-add multiplier. One partial
//            product is accumulated per clock, so a WIDTH x WIDTH product
//            takes WIDTH cycles instead of a full combinational array.
//            Operands and result each use a valid/ready handshake.
//
// Parameters:
//   WIDTH  operand width in bits (2..32); product is 2*WIDTH bits
//   CNT_W  bit-counter width, derived from WIDTH (do not override)
//
// Ports:
//   clk            in   1        clock, rising-edge active
//   rst_n          in   1        asynchronous active-low reset
//   in_valid_i     in   1        operands a_i/b_i valid
//   in_ready_o     out  1        block can accept operands (IDLE)
//   a_i            in   WIDTH    multiplicand
//   b_i            in   WIDTH    multiplier
//   signed_mode_i  in   1        (SEQ_MULT_SIGNED_EN only) operands are
//                                two's complement, sampled at acceptance
//   out_valid_o    out  1        prod_o valid, held until accepted
//   out_ready_i    in   1        consumer accepts prod_o
//   prod_o         out  2*WIDTH  product a*b
//   busy_o         out  1        high while running or holding a result
//
// Build option:
//   SEQ_MULT_SIGNED_EN  when defined, adds signed_mode_i and the
//                       magnitude/negation logic for signed products.
//
// Revision : 1.0  initial release
// ============================================================================

module seq_mult #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
`ifdef SEQ_MULT_SIGNED_EN
  input  logic                 signed_mode_i,
`endif
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [2*WIDTH-1:0]   prod_o,
  output logic                 busy_o
);

  localparam int PW = 2 * WIDTH;

  // FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Counter value present during the final RUN cycle
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]        state_q,  state_d;
  logic [PW-1:0]     mcand_q,  mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [PW-1:0]     acc_q,    acc_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [PW-1:0]     prod_q,   prod_d;
`ifdef SEQ_MULT_SIGNED_EN
  logic              neg_q,    neg_d;
`endif

  // --------------------------------------------------------------------------
  // Operand conditioning: the shift-add core always works on magnitudes.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0]  w_a_mag;
  logic [WIDTH-1:0]  w_b_mag;
  logic              w_neg;

`ifdef SEQ_MULT_SIGNED_EN
  logic              w_a_neg;
  logic              w_b_neg;

  assign w_a_neg = signed_mode_i & a_i[WIDTH-1];
  assign w_b_neg = signed_mode_i & b_i[WIDTH-1];

  // Unary minus in WIDTH bits yields the magnitude even for the most
  // negative value: -(-2^(W-1)) wraps to 2^(W-1), which is the correct
  // unsigned magnitude.
  assign w_a_mag = w_a_neg ? (-a_i) : a_i;
  assign w_b_mag = w_b_neg ? (-b_i) : b_i;
  assign w_neg   = w_a_neg ^ w_b_neg;
`else
  assign w_a_mag = a_i;
  assign w_b_mag = b_i;
  assign w_neg   = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Datapath: accumulator plus this cycle's partial product
  // --------------------------------------------------------------------------
  logic [PW-1:0] w_pp;
  logic [PW-1:0] w_acc_sum;
  logic [PW-1:0] w_result;

  assign w_pp      = mplier_q[0] ? mcand_q : '0;
  assign w_acc_sum = acc_q + w_pp;

`ifdef SEQ_MULT_SIGNED_EN
  // Magnitude product is at most 2^(2W-2), so negation never overflows.
  assign w_result  = neg_q ? (-w_acc_sum) : w_acc_sum;
`else
  assign w_result  = w_acc_sum;
`endif

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
`ifdef SEQ_MULT_SIGNED_EN
    neg_d    = neg_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (in_valid_i) begin
          mcand_d  = {{WIDTH{1'b0}}, w_a_mag};
          mplier_d = w_b_mag;
          acc_d    = '0;
          cnt_d    = '0;
`ifdef SEQ_MULT_SIGNED_EN
          neg_d    = w_neg;
`endif
          state_d  = ST_RUN;
        end
      end

      ST_RUN: begin
        // No early exit on zero operands: latency is always WIDTH cycles.
        acc_d    = w_acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == C_LAST) begin
          // Final add: result goes straight to prod so it is stable in DONE.
          prod_d  = w_result;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        // Inputs are never accepted here, even during the output handshake.
        if (out_ready_i) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
`ifdef SEQ_MULT_SIGNED_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
`ifdef SEQ_MULT_SIGNED_EN
      neg_q    <= neg_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Outputs (decoded from state so reset takes effect immediately)
  // --------------------------------------------------------------------------
  assign in_ready_o  = (state_q == ST_IDLE);
  assign out_valid_o = (state_q == ST_DONE);
  assign busy_o      = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign prod_o      = prod_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_mult.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_mult
// Purpose  : Self-checking bench for seq_mult. A negedge monitor scores every
//            accepted operand pair against an arithmetic reference product,
//            checks handshake timing, hold behaviour and latency. Directed
//            cases and a randomized phase drive a WIDTH=4 instance; a second
//            WIDTH=8 instance covers the wide corner. Honours
//            SEQ_MULT_SIGNED_EN.
// Revision : 1.0  initial release
// ============================================================================

module tb_seq_mult;

  localparam int W  = 4;
  localparam int PW = 2 * W;
`ifdef SEQ_MULT_SIGNED_EN
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam bit SIGNED_BUILD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          signed_mode;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] prod;
  logic          busy;

  // WIDTH=8 instance
  logic          in_valid8;
  logic          in_ready8;
  logic [7:0]    a8;
  logic [7:0]    b8;
  logic          signed_mode8;
  logic          out_valid8;
  logic          out_ready8;
  logic [15:0]   prod8;
  logic          busy8;

  always #5 clk = ~clk;

  seq_mult #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .a_i           (a),
    .b_i           (b),
`ifdef SEQ_MULT_SIGNED_EN
    .signed_mode_i (signed_mode),
`endif
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .prod_o        (prod),
    .busy_o        (busy)
  );

  seq_mult #(.WIDTH(8)) dut8 (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid_i    (in_valid8),
    .in_ready_o    (in_ready8),
    .a_i           (a8),
    .b_i           (b8),
`ifdef SEQ_MULT_SIGNED_EN
    .signed_mode_i (signed_mode8),
`endif
    .out_valid_o   (out_valid8),
    .out_ready_i   (out_ready8),
    .prod_o        (prod8),
    .busy_o        (busy8)
  );

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               tag, obs, obs, exp, exp, $time);
    end
  endtask

  // Reference: plain integer product of the operand values.
  function automatic logic [PW-1:0] ref_prod(input logic [W-1:0] x,
                                             input logic [W-1:0] y,
                                             input logic sm);
    longint xi;
    longint yi;
    longint p;
    xi = longint'(x);
    yi = longint'(y);
    if (sm) begin
      if (x[W-1]) xi = xi - (longint'(1) << W);
      if (y[W-1]) yi = yi - (longint'(1) << W);
    end
    p = xi * yi;
    return p[PW-1:0];
  endfunction

  // --------------------------------------------------------------------------
  // Monitor / scoreboard (samples on the falling edge)
  // --------------------------------------------------------------------------
  int            cyc = 0;
  logic [PW-1:0] exp_q[$];
  int            edge_q[$];
  logic          prev_ov;
  logic          prev_or;
  logic [PW-1:0] prev_prod;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov   <= 1'b0;
      prev_or   <= 1'b0;
      prev_prod <= '0;
    end else begin
      check("busy_vs_ready", {63'd0, busy}, {63'd0, !in_ready});
      if (prev_ov && !prev_or) begin
        check("bp_hold_valid", {63'd0, out_valid}, 64'd1);
        check("bp_hold_prod", 64'(prod), 64'(prev_prod));
      end
      if (prev_ov && prev_or) begin
        check("hs_drop_valid", {63'd0, out_valid}, 64'd0);
        check("hs_back_idle", {63'd0, in_ready}, 64'd1);
        check("hs_prod_hold", 64'(prod), 64'(prev_prod));
      end
      if (out_valid && !prev_ov) begin
        if (edge_q.size() == 0) check("spurious_valid", 64'd1, 64'd0);
        else check("latency", 64'(cyc - edge_q[0]), 64'(W));
      end
      if (out_valid && out_ready && exp_q.size() != 0) begin
        check("prod", 64'(prod), 64'(exp_q.pop_front()));
        void'(edge_q.pop_front());
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_prod(a, b, signed_mode));
        edge_q.push_back(cyc + 1);
      end
      prev_ov   <= out_valid;
      prev_or   <= out_ready;
      prev_prod <= prod;
    end
  end

  // Random backpressure generator
  bit rand_or = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_or) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // --------------------------------------------------------------------------
  // Driver tasks (called 1 time unit after a rising edge)
  // --------------------------------------------------------------------------
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic sm, input bit hold, output int edge_o);
    a           = x;
    b           = y;
    signed_mode = sm & SIGNED_BUILD;
    in_valid    = 1'b1;
    edge_o      = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        edge_o = cyc + 1;
        @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;
        // Operand changes after acceptance must have no effect.
        a           = W'($urandom);
        b           = W'($urandom);
        signed_mode = 1'($urandom_range(0, 1)) & SIGNED_BUILD;
        return;
      end
      @(posedge clk);
      #1;
    end
    check("accept_timeout", 64'd1, 64'd0);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && in_ready) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    check("drain_timeout", 64'd1, 64'd0);
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  int e1, e2, e3, e8;
  bit saw_valid;

  initial begin
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    a            = '0;
    b            = '0;
    signed_mode  = 1'b0;
    out_ready    = 1'b1;
    in_valid8    = 1'b0;
    a8           = '0;
    b8           = '0;
    signed_mode8 = 1'b0;
    out_ready8   = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_prod", 64'(prod), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic 13*9, in_ready low while busy
    send(4'b1101, 4'b1001, 1'b0, 1'b0, e1);
    @(negedge clk);
    check("run_in_ready", {63'd0, in_ready}, 64'd0);
    check("run_busy", {63'd0, busy}, 64'd1);
    @(posedge clk);
    #1;
    drain();
    check("t1_prod", 64'(prod), 64'd117);

    // Back-to-back with in_valid held high
    send(4'd10, 4'd11, 1'b0, 1'b1, e1);
    send(4'd8,  4'd8,  1'b0, 1'b1, e2);
    send(4'd15, 4'd1,  1'b0, 1'b0, e3);
    check("b2b_spacing1", 64'(e2 - e1), 64'(W + 2));
    check("b2b_spacing2", 64'(e3 - e2), 64'(W + 2));
    drain();
    check("b2b_last_prod", 64'(prod), 64'd15);

    // Backpressure
    out_ready = 1'b0;
    send(4'd5, 4'd4, 1'b0, 1'b0, e1);
    repeat (W + 10) @(posedge clk);
    #1;
    check("bp_valid_before", {63'd0, out_valid}, 64'd1);
    check("bp_prod_before", 64'(prod), 64'd20);
    out_ready = 1'b1;
    drain();
    check("bp_prod_after", 64'(prod), 64'd20);

    // Reset in the middle of RUN
    send(4'd1, 4'd6, 1'b0, 1'b0, e1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_prod", 64'(prod), 64'd0);
    exp_q.delete();
    edge_q.delete();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    saw_valid = 1'b0;
    for (int k = 0; k < W + 4; k++) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    check("post_rst_no_valid", {63'd0, saw_valid}, 64'd0);
    @(posedge clk);
    #1;
    send(4'd3, 4'd3, 1'b0, 1'b0, e1);
    drain();
    check("post_rst_prod", 64'(prod), 64'd9);

    // Corners
    send(4'd0, 4'd15, 1'b0, 1'b0, e1);
    drain();
    check("zero_prod", 64'(prod), 64'd0);
    send(4'd15, 4'd15, 1'b0, 1'b0, e1);
    drain();
    check("max_prod", 64'(prod), 64'd225);

`ifdef SEQ_MULT_SIGNED_EN
    send(4'hD, 4'h5, 1'b1, 1'b0, e1);
    drain();
    check("signed_neg", 64'(prod), 64'h00F1);
    send(4'h8, 4'h8, 1'b1, 1'b0, e1);
    drain();
    check("signed_minmin", 64'(prod), 64'h0040);
    send(4'hD, 4'h5, 1'b0, 1'b0, e1);
    drain();
    check("signed_off", 64'(prod), 64'd65);
`endif

    // Randomized operands with random backpressure
    rand_or = 1'b1;
    for (int n = 0; n < 40; n++) begin
      send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), e1);
    end
    in_valid = 1'b0;
    drain();
    rand_or = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    // WIDTH=8: 255*255
    a8        = 8'd255;
    b8        = 8'd255;
    in_valid8 = 1'b1;
    @(negedge clk);
    check("w8_ready", {63'd0, in_ready8}, 64'd1);
    e8 = cyc + 1;
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    e1 = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid8) begin
        e1 = cyc;
        break;
      end
    end
    check("w8_latency", 64'(e1 - e8), 64'd8);
    check("w8_prod", 64'(prod8), 64'd65025);
    @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
